// File: rtl/lab_pkg.sv
// Shared definitions for the pushbutton front end: FSM state encoding and
// the 50 MHz default timing constants used by the top-level parameters.
`timescale 1ns/1ps
package lab_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    HELD       = 3'd2,
    RPT        = 3'd3,
    DB_RELEASE = 3'd4
  } db_state_e;

  // 50 MHz system clock: 20 ms debounce, 0.5 s hold, 100 ms repeat period.
  localparam int unsigned CLK_HZ                = 50_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_50MHZ = 1_000_000;
  localparam int unsigned HOLD_CYCLES_50MHZ     = 25_000_000;
  localparam int unsigned REPEAT_CYCLES_50MHZ   = 5_000_000;
  localparam int unsigned CNT_W_50MHZ           = 25;

endpackage : lab_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow asynchronous inputs (buttons, switches).
// Both stages load rst_val_i on reset so a released input reads idle.
`timescale 1ns/1ps
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] rst_val_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value; blocking here would collapse the two stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= rst_val_i;
      sync_q <= rst_val_i;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/key_debounce.sv
// Debounced pushbutton conditioner: synchronises an active-low key and emits
// registered step pulses (press and auto-repeat) plus a release pulse.
`timescale 1ns/1ps
module key_debounce
  import lab_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_50MHZ,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_50MHZ,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned CNT_W           = CNT_W_50MHZ
) (
  input  logic clk,
  input  logic R,
  input  logic key_n,
  output logic pressed,
  output logic step,
  output logic release_p
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic             key_sync;
  logic             key_s;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed_q, pressed_d;
  logic             step_q, step_d;
  logic             release_q, release_d;

  sync_2ff #(.W(1)) u_key_sync (
    .clk       (clk),
    .rst       (R),
    .rst_val_i (1'b1),
    .d_i       (key_n),
    .q_o       (key_sync)
  );

  assign key_s = ~key_sync;

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      step_q    <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      step_q    <= step_d;
      release_q <= release_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    pressed_d = pressed_q;
    step_d    = 1'b0;
    release_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (key_s) begin
          state_d = DB_PRESS;
          cnt_d   = '0;
        end
      end

      DB_PRESS: begin
        if (!key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = HELD;
          cnt_d     = '0;
          step_d    = 1'b1;
          pressed_d = 1'b1;
        end
      end

      HELD: begin
        if (!key_s) begin
          state_d = DB_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          if (REPEAT_EN) begin
            state_d = RPT;
            cnt_d   = '0;
            step_d  = 1'b1;
          end else begin
            cnt_d = cnt_q;
          end
        end
      end

      RPT: begin
        if (!key_s) begin
          state_d = DB_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == RPT_LAST) begin
          cnt_d  = '0;
          step_d = 1'b1;
        end
      end

      DB_RELEASE: begin
        // A bounce back to pressed restarts the hold timer from zero.
        if (key_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          pressed_d = 1'b0;
          release_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign pressed   = pressed_q;
  assign step      = step_q;
  assign release_p = release_q;

endmodule : key_debounce

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: one instance with auto-repeat, one
// without, both fed the same key and reset, plus an 8-bit step counter.
`timescale 1ns/1ps
module tb_key_debounce;
  import lab_pkg::*;

  typedef struct packed {
    logic is_step;
    int   cyc;
  } ev_t;

  logic clk   = 1'b0;
  logic R     = 1'b1;
  logic key_n = 1'b1;
  logic pressed_a, step_a, rel_a;
  logic pressed_b, step_b, rel_b;

  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  ev_t  q_a[$];
  ev_t  q_b[$];
  ev_t  ea, eb;

  logic [7:0] ctr;
  logic       ctr_clr = 1'b1;

  key_debounce #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (10),
    .REPEAT_CYCLES   (3),
    .REPEAT_EN       (1'b1),
    .CNT_W           (4)
  ) dut_a (
    .clk       (clk),
    .R         (R),
    .key_n     (key_n),
    .pressed   (pressed_a),
    .step      (step_a),
    .release_p (rel_a)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (10),
    .REPEAT_CYCLES   (3),
    .REPEAT_EN       (1'b0),
    .CNT_W           (4)
  ) dut_b (
    .clk       (clk),
    .R         (R),
    .key_n     (key_n),
    .pressed   (pressed_b),
    .step      (step_b),
    .release_p (rel_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream hex counter with step as its clock enable.
  always @(posedge clk) begin
    if (ctr_clr)     ctr <= 8'h00;
    else if (step_a) ctr <= ctr + 8'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic exp_a(input logic s, input int c);
    q_a.push_back(ev_t'{is_step: s, cyc: c});
  endtask

  task automatic exp_b(input logic s, input int c);
    q_b.push_back(ev_t'{is_step: s, cyc: c});
  endtask

  task automatic exp_both(input logic s, input int c);
    exp_a(s, c);
    exp_b(s, c);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  // Monitor for the auto-repeat instance.
  always @(negedge clk) begin
    if (!R) begin
      if (q_a.size() != 0 && q_a[0].cyc < cyc) begin
        check("a_missing_pulse", 32'hFFFF_FFFF, q_a[0].cyc);
        void'(q_a.pop_front());
      end
      if (step_a || rel_a) begin
        check("a_step_rel_exclusive", step_a & rel_a, 0);
        if (q_a.size() == 0) begin
          check("a_unexpected_pulse", cyc, 32'hFFFF_FFFF);
        end else begin
          ea = q_a.pop_front();
          check("a_pulse_kind", step_a, ea.is_step);
          check("a_pulse_cycle", cyc, ea.cyc);
        end
      end
    end
  end

  // Monitor for the no-repeat instance.
  always @(negedge clk) begin
    if (!R) begin
      if (q_b.size() != 0 && q_b[0].cyc < cyc) begin
        check("b_missing_pulse", 32'hFFFF_FFFF, q_b[0].cyc);
        void'(q_b.pop_front());
      end
      if (step_b || rel_b) begin
        check("b_step_rel_exclusive", step_b & rel_b, 0);
        if (q_b.size() == 0) begin
          check("b_unexpected_pulse", cyc, 32'hFFFF_FFFF);
        end else begin
          eb = q_b.pop_front();
          check("b_pulse_kind", step_b, eb.is_step);
          check("b_pulse_cycle", cyc, eb.cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2;

    repeat (3) @(negedge clk);
    check("rst_pressed_a", pressed_a, 0);
    check("rst_step_a",    step_a,    0);
    check("rst_release_a", rel_a,     0);
    check("rst_pressed_b", pressed_b, 0);
    check("rst_step_b",    step_b,    0);
    check("rst_release_b", rel_b,     0);
    R = 1'b0;
    repeat (3) @(negedge clk);

    // Clean press: 8 low samples, step at k+6, release at j+6 = k+14.
    k = cyc + 1;
    exp_both(1'b1, k + 6);
    exp_both(1'b0, k + 14);
    key_n = 1'b0;
    wait_until(k + 5);
    check("clean_pressed_before", pressed_a, 0);
    wait_until(k + 6);
    check("clean_pressed_a", pressed_a, 1);
    check("clean_pressed_b", pressed_b, 1);
    wait_until(k + 7);
    key_n = 1'b1;
    wait_until(k + 13);
    check("clean_pressed_hold", pressed_a, 1);
    wait_until(k + 14);
    check("clean_pressed_fall", pressed_a, 0);
    repeat (6) @(negedge clk);

    // Bounce: 3 low samples are rejected.
    k = cyc + 1;
    key_n = 1'b0;
    wait_until(k + 2);
    key_n = 1'b1;
    wait_until(k + 8);
    check("bounce_pressed", pressed_a, 0);
    check("bounce_idle", dut_a.state_q, IDLE);
    repeat (4) @(negedge clk);

    // Auto-repeat: held 30 samples, release at j = k+30.
    k = cyc + 1;
    exp_a(1'b1, k + 6);
    exp_a(1'b1, k + 16);
    exp_a(1'b1, k + 19);
    exp_a(1'b1, k + 22);
    exp_a(1'b1, k + 25);
    exp_a(1'b1, k + 28);
    exp_a(1'b1, k + 31);
    exp_a(1'b0, k + 36);
    exp_b(1'b1, k + 6);
    exp_b(1'b0, k + 36);
    key_n = 1'b0;
    wait_until(k + 29);
    key_n = 1'b1;
    wait_until(k + 40);

    // Release glitch: high at samples k+9,k+10; HELD re-entered at k+13.
    k = cyc + 1;
    exp_a(1'b1, k + 6);
    exp_a(1'b1, k + 23);
    exp_a(1'b1, k + 26);
    exp_a(1'b0, k + 31);
    exp_b(1'b1, k + 6);
    exp_b(1'b0, k + 31);
    key_n = 1'b0;
    wait_until(k + 8);
    key_n = 1'b1;
    wait_until(k + 10);
    key_n = 1'b0;
    wait_until(k + 14);
    check("glitch_pressed_a", pressed_a, 1);
    check("glitch_pressed_b", pressed_b, 1);
    wait_until(k + 24);
    key_n = 1'b1;
    wait_until(k + 36);

    // Reset mid-debounce, key held through reset.
    k = cyc + 1;
    key_n = 1'b0;
    wait_until(k + 4);
    #2 R = 1'b1;
    #1;
    check("rst_dbp_pressed", pressed_a, 0);
    check("rst_dbp_step",    step_a,    0);
    check("rst_dbp_state",   dut_a.state_q, IDLE);
    repeat (2) @(negedge clk);
    #2 R = 1'b0;
    k2 = cyc + 1;
    exp_both(1'b1, k2 + 6);
    exp_both(1'b0, k2 + 14);
    @(negedge clk);
    wait_until(k2 + 5);
    check("rst_dbp_no_early", pressed_a, 0);
    wait_until(k2 + 7);
    key_n = 1'b1;
    wait_until(k2 + 20);

    // Reset mid-repeat, asserted while a repeat step is on the output.
    k = cyc + 1;
    exp_a(1'b1, k + 6);
    exp_a(1'b1, k + 16);
    exp_b(1'b1, k + 6);
    key_n = 1'b0;
    wait_until(k + 16);
    #2 R = 1'b1;
    #1;
    check("rst_rpt_step_a",    step_a,    0);
    check("rst_rpt_pressed_a", pressed_a, 0);
    check("rst_rpt_release_a", rel_a,     0);
    check("rst_rpt_pressed_b", pressed_b, 0);
    key_n = 1'b1;
    repeat (2) @(negedge clk);
    #2 R = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_rpt_after_pressed", pressed_a, 0);

    // Integration: 300 clean presses into the 8-bit counter.
    ctr_clr = 1'b0;
    for (int i = 0; i < 300; i++) begin
      k = cyc + 1;
      exp_both(1'b1, k + 6);
      exp_both(1'b0, k + 14);
      key_n = 1'b0;
      wait_until(k + 7);
      key_n = 1'b1;
      wait_until(k + 17);
    end
    repeat (4) @(negedge clk);
    check("counter_value", ctr, 8'h2C);
    check("display_hi", hex_char(ctr[7:4]), 8'h32);
    check("display_lo", hex_char(ctr[3:0]), 8'h43);
    check("queue_a_drained", q_a.size(), 0);
    check("queue_b_drained", q_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_key_debounce

// File: doc/key_debounce.md
# key_debounce

Front-end conditioner for a raw active-low pushbutton. It synchronises the button to the system clock, debounces press and release, and emits single-cycle `step` pulses, including optional auto-repeat while the button is held. It sits directly upstream of the 8-bit hex-displayed counter: `step` drives the counter's clock-enable on the same `clk`, replacing the practice of clocking the counter from the button itself.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: stable-input cycles required to accept a press or a release (20 ms at 50 MHz); must be ≥ 1.
- `HOLD_CYCLES`, default 25_000_000: cycles the button must be held after the accepted press before auto-repeat starts.
- `REPEAT_CYCLES`, default 5_000_000: auto-repeat period.
- `REPEAT_EN`, default 1: 0 disables auto-repeat.
- `CNT_W`, default 25: timer width; must hold max(all cycle parameters) − 1.
- `clk`  in  1  system clock; single clock domain.
- `R`  in  1  reset; asynchronous, active-high.
- `key_n`  in  1  raw pushbutton, 0 = pressed, asynchronous to `clk`.
- `pressed`  out  1  debounced level, 1 = button held.
- `step`  out  1  one-cycle pulse per accepted press and per repeat.
- `release_p`  out  1  one-cycle pulse per accepted release.

## Operation
- Two-flop synchroniser on `key_n`, reset to 1. Internal `key_s` = inverted synchroniser output (1 = pressed).
- FSM with one shared `CNT_W`-bit timer `cnt`. `cnt` is cleared on every state change and increments otherwise.
- IDLE: `key_s`=1 → DB_PRESS.
- DB_PRESS: `key_s`=0 → IDLE, with no pulse (bounce rejected). When `cnt`==DEBOUNCE_CYCLES−1 and `key_s`=1 → HELD; `step`←1, `pressed`←1.
- HELD: `key_s`=0 → DB_RELEASE. When `cnt`==HOLD_CYCLES−1 and REPEAT_EN=1 → RPT; `step`←1. With REPEAT_EN=0, `cnt` saturates and the FSM stays in HELD.
- RPT: `key_s`=0 → DB_RELEASE. When `cnt`==REPEAT_CYCLES−1, `step`←1 and `cnt`←0, staying in RPT.
- DB_RELEASE: `key_s`=1 → HELD, with `cnt` cleared so the hold timer restarts; no pulse, and `pressed` stays 1. When `cnt`==DEBOUNCE_CYCLES−1 and `key_s`=0 → IDLE; `pressed`←0, `release_p`←1.
- All outputs are registered. `step` and `release_p` are never high in the same cycle.

## Timing
- Reset: `R`=1 immediately forces state=IDLE, `cnt`=0, synchroniser=1, and `pressed`=`step`=`release_p`=0. No pulses are emitted on reset release, even if the button is held; a press held through reset is accepted once the debounce completes after reset.
- Press latency: let k be the first `clk` edge that samples `key_n`=0. Then `step` is high for exactly the one cycle after edge k+2+DEBOUNCE_CYCLES, and `pressed` rises at that same edge.
- First repeat: at the edge 10·… that is, HOLD_CYCLES edges after the press `step` edge. Subsequent repeats follow every REPEAT_CYCLES edges.
- Release latency: let j be the first edge sampling `key_n`=1. Then `release_p` fires, and `pressed` falls, at edge j+2+DEBOUNCE_CYCLES.
- Reset asserted mid-debounce or mid-repeat aborts the operation with no partial pulse.

## Structure
- Shared package `lab_pkg` holds:
  - the FSM state encoding: IDLE, DB_PRESS, HELD, RPT, DB_RELEASE, as 3-bit constants;
  - the 50 MHz default timing constants, reused by the top level.
- Sub-module `sync_2ff` is the reusable synchroniser, with a reset value port. It is also to be used for switch inputs.

## Test plan
Use DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.
- Reset: assert `R` during DB_PRESS and during RPT → all outputs 0 within the same cycle; no `step` after deassertion until a fresh 4-cycle stable press completes.
- Clean press, held 8 cycles then released (k = first low sample): `step` only at edge k+6, `pressed` high from k+6; `release_p` at j+6; exactly one `step` in total.
- Bounce: `key_n` low for 3 cycles then high → no `step`, `pressed` stays 0, FSM back in IDLE.
- Auto-repeat, button held 30 cycles: `step` at edges k+6, k+16, k+19, k+22, k+25, … until release; with REPEAT_EN=0 only the k+6 pulse.
- Release glitch: in HELD, `key_n` high for 2 cycles → no `release_p`, `pressed` stays 1, first repeat at HOLD_CYCLES after the return to HELD.
- Integration: drive the 8-bit counter enable from `step` and issue 300 clean presses → counter = 0x2C, displays read "2C".
